// File: rtl/yolo_sigmoid_pkg.sv
// Shared constants, FSM state type and index clamp for the YOLO-layer sigmoid fraction ROM.
// Imported by the LUT reader and its optional skid buffer.
package yolo_sigmoid_pkg;

  localparam int SIG_ROM_AW = 8;
  localparam int SIG_ROM_DW = 14;
  localparam int SIG_CENTER = 91;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic                  sat;
    logic [SIG_ROM_AW-1:0] addr;
  } sig_idx_t;

  // Clamp a signed table index into the ROM range and flag when clamping happened.
  function automatic sig_idx_t sig_idx_sat(input logic signed [31:0] idx);
    sig_idx_t r;
    if (idx < 0) begin
      r.sat  = 1'b1;
      r.addr = '0;
    end else if (idx > (1 << SIG_ROM_AW) - 1) begin
      r.sat  = 1'b1;
      r.addr = '1;
    end else begin
      r.sat  = 1'b0;
      r.addr = idx[SIG_ROM_AW-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sigmoid_rd_skid.sv
// Two-entry valid/ready FIFO holding {frac, sat, tag} so the ROM can advance while the
// consumer stalls; occupancy exported so the parent can schedule a registered ready.
module sigmoid_rd_skid
  import yolo_sigmoid_pkg::*;
#(
  parameter int W = SIG_ROM_DW + 1 + 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_wr_vld,
  output logic         o_wr_rdy,
  input  logic [W-1:0] i_wr_dat,
  output logic         o_rd_vld,
  input  logic         i_rd_rdy,
  output logic [W-1:0] o_rd_dat,
  output logic [1:0]   o_cnt
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_cnt;
  logic         w_wr;
  logic         w_rd;

  assign o_wr_rdy = (r_cnt != 2'd2);
  assign o_rd_vld = (r_cnt != 2'd0);
  assign o_rd_dat = r_mem[r_rptr];
  assign o_cnt    = r_cnt;
  assign w_wr     = i_wr_vld & o_wr_rdy;
  assign w_rd     = o_rd_vld & i_rd_rdy;

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_wr_dat;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_wr) begin
        r_wptr <= ~r_wptr;
      end
      if (w_rd) begin
        r_rptr <= ~r_rptr;
      end
      r_cnt <= r_cnt + {1'b0, w_wr} - {1'b0, w_rd};
    end
  end

endmodule

// File: rtl/sigmoid_lut_reader.sv
// Maps signed activations to saturated sigmoid-ROM reads and streams {frac, sat, tag} out, 1 cycle latency.
// Default: combinational ready, ROM register is the data stage; SIGMOID_RD_SKID_EN adds a registered ready and 2-entry skid.
module sigmoid_lut_reader
  import yolo_sigmoid_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SHIFT  = 4,
  parameter int CENTER = SIG_CENTER,
  parameter int TAG_W  = 8
) (
  input  logic                     clka,
  input  logic                     rsta,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     ena,
  output logic [SIG_ROM_AW-1:0]    addra,
  input  logic [SIG_ROM_DW-1:0]    douta,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIG_ROM_DW-1:0]    out_frac,
  output logic                     out_sat,
  output logic [TAG_W-1:0]         out_tag
);

  logic signed [DATA_W-1:0] w_x_shr;
  logic signed [DATA_W+1:0] w_idx;
  sig_idx_t                 w_idx_sat;
  logic                     w_fire_in;

  // Two guard bits keep the centre offset from wrapping at the extremes of in_x.
  assign w_x_shr   = in_x >>> SHIFT;
  assign w_idx     = {{2{w_x_shr[DATA_W-1]}}, w_x_shr} + (DATA_W+2)'(CENTER);
  assign w_idx_sat = sig_idx_sat(32'(w_idx));
  assign addra     = w_idx_sat.addr;
  assign w_fire_in = in_valid & in_ready;
  assign ena       = w_fire_in;

`ifndef SIGMOID_RD_SKID_EN

  rd_state_e        r_state;
  logic             r_out_valid;
  logic             r_sat;
  logic [TAG_W-1:0] r_tag;

  // The ROM holds douta while ena is low, so a stalled result needs no local data copy.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
      r_tag       <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_fire_in) begin
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
          end
        end
        ST_FULL: begin
          if (out_ready & !w_fire_in) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
      endcase
      if (w_fire_in) begin
        r_sat <= w_idx_sat.sat;
        r_tag <= in_tag;
      end
    end
  end

  assign in_ready  = !r_out_valid | out_ready;
  assign out_valid = r_out_valid;
  assign out_frac  = douta;
  assign out_sat   = r_sat;
  assign out_tag   = r_tag;

`else

  localparam int SKID_W = SIG_ROM_DW + 1 + TAG_W;

  logic              r_s1_vld;
  logic              r_s1_sat;
  logic [TAG_W-1:0]  r_s1_tag;
  logic              r_in_ready;
  logic [SKID_W-1:0] w_s1_dat;
  logic [SKID_W-1:0] w_skid_dat;
  logic              w_skid_vld;
  logic              w_skid_rdy;
  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_skid_cnt;
  logic [1:0]        w_skid_cnt_nxt;

  // The s1 result is live on douta for one cycle only; anything not taken directly goes into the skid.
  assign w_s1_dat       = {douta, r_s1_sat, r_s1_tag};
  assign w_push         = r_s1_vld & (w_skid_vld | !out_ready) & w_skid_rdy;
  assign w_pop          = w_skid_vld & out_ready;
  assign w_skid_cnt_nxt = w_skid_cnt + {1'b0, w_push} - {1'b0, w_pop};

  sigmoid_rd_skid #(
    .W (SKID_W)
  ) u_skid (
    .i_clk    (clka),
    .i_rst    (rsta),
    .i_wr_vld (w_push),
    .o_wr_rdy (w_skid_rdy),
    .i_wr_dat (w_s1_dat),
    .o_rd_vld (w_skid_vld),
    .i_rd_rdy (out_ready),
    .o_rd_dat (w_skid_dat),
    .o_cnt    (w_skid_cnt)
  );

  // Ready only when at most one result is pending next cycle, so a new read always finds skid room.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      r_s1_vld   <= 1'b0;
      r_s1_sat   <= 1'b0;
      r_s1_tag   <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_s1_vld   <= w_fire_in;
      r_in_ready <= ({1'b0, w_skid_cnt_nxt} + {2'b00, w_fire_in}) <= 3'd1;
      if (w_fire_in) begin
        r_s1_sat <= w_idx_sat.sat;
        r_s1_tag <= in_tag;
      end
    end
  end

  assign in_ready                     = r_in_ready;
  assign out_valid                    = w_skid_vld | r_s1_vld;
  assign {out_frac, out_sat, out_tag} = w_skid_vld ? w_skid_dat : w_s1_dat;

`endif

endmodule

// File: tb/tb_sigmoid_lut_reader.sv
// Scoreboard bench for sigmoid_lut_reader with a registered ROM model on the read port.
module tb_sigmoid_lut_reader;

  logic        clka = 1'b0;
  logic        rsta = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic [7:0]  in_tag = '0;
  logic        ena;
  logic [7:0]  addra;
  logic [13:0] douta = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [13:0] out_frac;
  logic        out_sat;
  logic [7:0]  out_tag;

  int          n_tests = 0;
  int          n_fail = 0;
  int          rdy_mode = 0;
  logic [22:0] sb[$];
  logic        fired_prev = 1'b0;
  logic        stall_prev = 1'b0;
  logic [22:0] prev_out = '0;

  always #5 clka = ~clka;

  sigmoid_lut_reader dut (
    .clka      (clka),
    .rsta      (rsta),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_tag    (in_tag),
    .ena       (ena),
    .addra     (addra),
    .douta     (douta),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_frac  (out_frac),
    .out_sat   (out_sat),
    .out_tag   (out_tag)
  );

  function automatic logic [13:0] rom_val(input logic [7:0] a);
    case (a)
      8'd0:    return 14'd3128;
      8'd91:   return 14'd5000;
      8'd92:   return 14'd5784;
      8'd255:  return 14'd1000;
      default: return 14'((int'(a) * 97 + 13) % 16384);
    endcase
  endfunction

  function automatic logic [8:0] model_idx(input logic [15:0] x);
    int v;
    v = (int'($signed(x)) >>> 4) + 91;
    if (v < 0) return {1'b1, 8'd0};
    if (v > 255) return {1'b1, 8'hff};
    return {1'b0, v[7:0]};
  endfunction

  always @(posedge clka) begin
    if (ena) douta <= rom_val(addra);
  end

  always @(posedge clka) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clka) begin
    logic [8:0]  m;
    logic [22:0] e;
    if (rsta) begin
      fired_prev = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (fired_prev) chk("latency", 32'(out_valid), 32'd1);
      if (stall_prev) chk("stable", 32'({out_frac, out_sat, out_tag}), 32'(prev_out));
`ifndef SIGMOID_RD_SKID_EN
      if (out_valid && !out_ready) chk("ena_stall", 32'(ena), 32'd0);
`endif
      if (in_valid && in_ready) begin
        m = model_idx(in_x);
        chk("ena_fire", 32'(ena), 32'd1);
        chk("addra", 32'(addra), 32'(m[7:0]));
        sb.push_back({rom_val(m[7:0]), m[8], in_tag});
      end else begin
        chk("ena_idle", 32'(ena), 32'd0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("frac", 32'(out_frac), 32'(e[22:9]));
          chk("sat", 32'(out_sat), 32'(e[8]));
          chk("tag", 32'(out_tag), 32'(e[7:0]));
        end
      end
      fired_prev = in_valid && in_ready;
      stall_prev = out_valid && !out_ready;
      prev_out   = {out_frac, out_sat, out_tag};
    end
  end

  // Inputs change at posedge+1; returns the number of cycles the sample waited for acceptance.
  task automatic send(input logic [15:0] x, input logic [7:0] t, output int n);
    logic done;
    done = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_x = x;
    in_tag = t;
    while (!done) begin
      @(negedge clka);
      done = in_ready;
      @(posedge clka);
      #1;
      n++;
      if (!done && n > 300) begin
        chk("send_timeout", 32'(n), 32'd0);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 500) begin
      @(posedge clka);
      k++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    @(posedge clka);
    #1;
  endtask

  initial begin
    int n;
    int total;
    int v;
    rdy_mode = 0;
    repeat (3) @(posedge clka);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_ena", 32'(ena), 32'd0);
    @(posedge clka);
    #1;
    rsta = 1'b0;
`ifdef SIGMOID_RD_SKID_EN
    chk("rst_in_ready0", 32'(in_ready), 32'd0);
    @(posedge clka);
    #1;
`endif
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    send(16'h0000, 8'h11, n);
    @(negedge clka);
    chk("ctr_valid", 32'(out_valid), 32'd1);
    chk("ctr_frac", 32'(out_frac), 32'd5000);
    chk("ctr_sat", 32'(out_sat), 32'd0);
    chk("ctr_tag", 32'(out_tag), 32'h11);
    drain();

    send(16'h7fff, 8'h12, n);
    @(negedge clka);
    chk("psat_frac", 32'(out_frac), 32'd1000);
    chk("psat_sat", 32'(out_sat), 32'd1);
    drain();

    send(16'h8000, 8'h13, n);
    @(negedge clka);
    chk("nsat_frac", 32'(out_frac), 32'd3128);
    chk("nsat_sat", 32'(out_sat), 32'd1);
    drain();

    rdy_mode = 2;
    send(16'd16, 8'h21, n);
    fork
      send(16'd32, 8'h22, n);
      begin
        repeat (5) begin
          @(negedge clka);
          chk("stall_vld", 32'(out_valid), 32'd1);
          chk("stall_frac", 32'(out_frac), 32'd5784);
          chk("stall_tag", 32'(out_tag), 32'h21);
        end
        @(posedge clka);
        #1;
        rdy_mode = 0;
        @(negedge clka);
        @(negedge clka);
        chk("follow_vld", 32'(out_valid), 32'd1);
        chk("follow_tag", 32'(out_tag), 32'h22);
      end
    join
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 64; i++) begin
      v = int'($urandom_range(0, 4800)) - 2400;
      send((i % 3 == 0) ? 16'($urandom) : v[15:0], 8'($urandom), n);
    end
    drain();
    rdy_mode = 0;
    @(posedge clka);
    #1;
    total = 0;
    for (int i = 0; i < 64; i++) begin
      v = int'($urandom_range(0, 4800)) - 2400;
      send(v[15:0], 8'(i), n);
      total += n;
    end
    chk("thruput", 32'(total), 32'd64);
    drain();

    rdy_mode = 2;
    send(16'hfff0, 8'h31, n);
    @(negedge clka);
    chk("pre_rst_vld", 32'(out_valid), 32'd1);
    #1;
    rsta = 1'b1;
    #1;
    chk("async_rst_vld", 32'(out_valid), 32'd0);
    sb.delete();
    rdy_mode = 0;
    repeat (2) @(posedge clka);
    #1;
    rsta = 1'b0;
    send(16'd16, 8'h41, n);
    @(negedge clka);
    chk("post_rst_frac", 32'(out_frac), 32'd5784);
    chk("post_rst_tag", 32'(out_tag), 32'h41);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sigmoid_lut_reader.md
# sigmoid_lut_reader

Streaming requester and consumer for the YOLO-layer sigmoid fraction ROM (8-bit address, 14-bit data, one-cycle registered read gated by enable). It accepts signed fixed-point activations on a valid/ready stream and maps each one to a saturated ROM address. It drives the ROM read, absorbs the one-cycle read latency, and presents the 14-bit fraction, a saturation flag and a passthrough tag on an output stream with full backpressure. It sits between the conv output dequantiser and the YOLO box/objectness arithmetic.

## Interface
- DATA_W, 16: width of signed input activation.
- SHIFT, 4: arithmetic right shift applied to the input before indexing.
- CENTER, 91: ROM index for x = 0.
- TAG_W, 8: sideband tag width.
- clka  in  1  clock.
- rsta  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept the sample.
- in_x  in  DATA_W  signed activation.
- in_tag  in  TAG_W  sideband, returned unchanged.
- ena  out  1  ROM read enable.
- addra  out  8  ROM address.
- douta  in  14  ROM data; valid one cycle after `ena`, held while `ena` is low.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_frac  out  14  ROM fraction for the sample.
- out_sat  out  1  index was clamped to 0 or 255.
- out_tag  out  TAG_W  tag of the sample.

## Operation
- Index: `idx = (in_x >>> SHIFT) + CENTER`, computed signed in DATA_W+2 bits. Clamp to [0,255] to form `addra`. `sat = (idx < 0) | (idx > 255)`.
- Accept: `fire_in = in_valid & in_ready`. The output is `ena = fire_in`. `addra` is combinational from `in_x`.
- On `fire_in`, register `sat` and `in_tag` into the output stage and set `out_valid` on the next edge. `out_frac` is `douta` driven straight through, so the ROM register is the data stage.
- Stall: the ROM holds `douta` when `ena` is low. A stalled result is therefore stable with no extra data register.
- Ready (without skid): `in_ready = !out_valid | out_ready`.
- `out_valid` next-state logic:
  - Set on `fire_in`.
  - Otherwise cleared when `out_ready`.
  - Otherwise held.
- State: two states derived from `out_valid`.
  - EMPTY: nothing pending.
  - FULL: a result is presented.
  - EMPTY to FULL on `fire_in`.
  - FULL to EMPTY on `out_ready & !fire_in`.
  - FULL to FULL on `out_ready & fire_in` (back-to-back) or on `!out_ready` (stall).
- Simultaneous output handshake and new input: both occur in the same cycle, giving 1 sample per cycle sustained.

## Timing
- Reset values:
  - `out_valid` = 0, `out_sat` = 0, `out_tag` = 0.
  - `in_ready` = 1 (combinational path).
  - `ena` = 0.
  - `out_frac` follows `douta` and is don't-care while `out_valid` = 0.
- Latency: sample accepted at edge N appears with `out_valid` = 1 in cycle N+1.
- Throughput: 1 sample per clock while `out_ready` = 1.
- Rules: `out_*` stay stable while `out_valid & !out_ready`. `ena` is never asserted while a stalled result is being held.
- Reset mid-operation: a pending result is discarded. `out_valid` drops asynchronously, and the first post-reset `ena` issues a fresh read.

## Configuration
- `SIGMOID_RD_SKID_EN` defined:
  - `in_ready` becomes a register, cutting the combinational `out_ready`→`in_ready` path.
  - A 2-entry skid buffer holds {frac, sat, tag}.
  - The captured ROM data is stored in the skid, so the ROM can advance.
  - `in_ready` = 0 when the skid has 2 entries.
  - Latency is still 1 cycle when empty, and throughput is still 1 per cycle.
  - Reset empties the skid and sets `in_ready` to 1 one cycle after reset release.
- `SIGMOID_RD_SKID_EN` undefined: the combinational-ready behaviour described above.

## Structure
- Shared package `yolo_sigmoid_pkg` holds:
  - `SIG_ROM_AW` = 8 and `SIG_ROM_DW` = 14.
  - `SIG_CENTER` = 91, the source for the CENTER default.
  - The `sig_idx_sat` clamp function.
- Sub-module `sigmoid_rd_skid` is the 2-entry skid FIFO: valid/ready both sides, width `SIG_ROM_DW`+1+TAG_W. It is instantiated only under `SIGMOID_RD_SKID_EN`.
- The ROM stays outside this block; it is connected at the YOLO-layer top.

## Test plan
- Centre:
  - Stimulus: reset, then `in_x` = 0, tag 0x11, `out_ready` = 1, ROM model attached.
  - Required response: `addra` = 91; `out_frac` = 5000, `out_sat` = 0, `out_tag` = 0x11 one cycle later.
- Positive saturation:
  - Stimulus: `in_x` = 0x7FFF.
  - Required response: `addra` = 255, `out_sat` = 1, `out_frac` = 1000.
- Negative saturation:
  - Stimulus: `in_x` = 0x8000.
  - Required response: `addra` = 0, `out_sat` = 1, `out_frac` = 3128.
- Stall:
  - Stimulus: send x = 16 (idx 92), then hold `out_ready` = 0 for 5 cycles while `in_valid` = 1.
  - Required response: `out_frac` = 5784 stable; `ena` = 0 throughout; no sample lost.
  - On release, the next queued sample follows on the next cycle.
- Streaming:
  - Stimulus: 64 random samples with random `out_ready`.
  - Required response: output sequence equals the reference-model clamp/lookup in order with tags intact; 64 cycles for 64 samples when `out_ready` = 1.
- Reset mid-stall:
  - Stimulus: assert `rsta` asynchronously while `out_valid` = 1.
  - Required response: `out_valid` goes to 0 immediately; the first sample after reset returns correct data.
  - Repeat with `SIGMOID_RD_SKID_EN` defined.
